// File: rtl/line_mem_pkg.sv
// Shared defaults, the out-of-range read fill pattern and the line-index range check
// for the line memory model.
package line_mem_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;
  localparam int DEPTH_DEF  = 256;
  localparam int RD_LAT_DEF = 4;
  localparam int QDEPTH_DEF = 4;

  localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;

  function automatic logic line_in_range(input logic [63:0] idx, input int depth);
    return idx < 64'(depth);
  endfunction

endpackage

// File: rtl/rd_delay_queue.sv
// In-order read return queue: each entry carries its snapshot data and a countdown
// that ticks every cycle; the head is popped by the parent when its countdown hits 1.
module rd_delay_queue #(
  parameter int DATA_W = 256,
  parameter int QDEPTH = 4,
  parameter int CNT_W  = 4,
  parameter int QCNT_W = $clog2(QDEPTH + 1)
) (
  input  logic              master_clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [CNT_W-1:0]  push_cnt,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  head_cnt,
  output logic [QCNT_W-1:0] count
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [DATA_W-1:0] data_q [QDEPTH];
  logic [CNT_W-1:0]  cnt_q  [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  always_ff @(posedge master_clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + QCNT_W'(push) - QCNT_W'(pop);
    end
  end

  // Free slots count down too; harmless since a push always reloads its slot.
  always_ff @(posedge master_clk) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
    end
    if (push && !reset) begin
      data_q[wr_ptr] <= push_data;
      cnt_q[wr_ptr]  <= push_cnt;
    end
  end

  assign head_data = data_q[rd_ptr];
  assign head_cnt  = cnt_q[rd_ptr];

endmodule

// File: rtl/line_mem_model.sv
// Line-wide memory model with fixed-latency in-order reads, word bypass mode and a
// sticky error flag. Optional counters enabled by LINE_MEM_MODEL_STATS_EN.
module line_mem_model
  import line_mem_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic              master_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a,
  input  logic              read,
  input  logic              write,
  input  logic [LINE_W-1:0] wd,
  input  logic [3:0]        be,
  input  logic              bypass,
  output logic              ready,
  output logic [LINE_W-1:0] rd,
  output logic              valid,
  output logic              err,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam int WORDS  = LINE_W / 32;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = 4;
  localparam int QCNT_W = $clog2(QDEPTH + 1);

  logic [LINE_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [MEM_AW-1:0] mem_idx;
  logic [WSEL_W-1:0] wsel;
  logic              in_rng;
  logic              accept, do_read, do_write, err_set, err_q;
  logic [LINE_W-1:0] cur_line, wr_line, push_line, head_data;
  logic [CNT_W-1:0]  head_cnt;
  logic [QCNT_W-1:0] q_count;

  assign idx     = a[ADDR_W-1:OFF_W];
  assign mem_idx = MEM_AW'(idx);
  assign wsel    = (WORDS > 1) ? WSEL_W'(a >> 2) : '0;
  assign in_rng  = line_in_range(64'(idx), DEPTH);

  assign accept   = (read | write) & ready;
  assign do_read  = accept & read & ~write;
  assign do_write = accept & write & ~read;
  assign err_set  = accept & ((read & write) | ~in_rng);

  always_comb begin
    cur_line = mem[mem_idx];
    wr_line  = cur_line;
    if (bypass) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) wr_line[32*int'(wsel) + 8*b +: 8] = wd[8*b +: 8];
      end
    end else begin
      wr_line = wd;
    end
    if (!in_rng)     push_line = {WORDS{ERR_PATTERN}};
    else if (bypass) push_line = LINE_W'(cur_line[32*int'(wsel) +: 32]);
    else             push_line = cur_line;
  end

  always_ff @(posedge master_clk) begin
    if (do_write && in_rng) mem[mem_idx] <= wr_line;
  end

  always_ff @(posedge master_clk) begin
    if (reset)        err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  rd_delay_queue #(
    .DATA_W (LINE_W),
    .QDEPTH (QDEPTH),
    .CNT_W  (CNT_W),
    .QCNT_W (QCNT_W)
  ) u_queue (
    .master_clk (master_clk),
    .reset      (reset),
    .push       (do_read),
    .push_data  (push_line),
    .push_cnt   (CNT_W'(RD_LAT)),
    .pop        (valid),
    .head_data  (head_data),
    .head_cnt   (head_cnt),
    .count      (q_count)
  );

  // A popping head frees its slot in the same cycle, so a full queue still accepts.
  assign valid = ~reset & (q_count != '0) & (head_cnt == CNT_W'(1));
  assign ready = ~reset & ((q_count < QCNT_W'(QDEPTH)) | valid);
  assign rd    = valid ? head_data : '0;
  assign err   = err_q & ~reset;

`ifdef LINE_MEM_MODEL_STATS_EN
  always_ff @(posedge master_clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (do_read && rd_count != '1)  rd_count <= rd_count + 32'd1;
      if (do_write && wr_count != '1) wr_count <= wr_count + 32'd1;
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_line_mem_model.sv
// Directed bench for line_mem_model: a per-cycle vector table plus hand-written burst
// and reset-with-reads-in-flight sequences on RD_LAT=4 and RD_LAT=6 instances.
module tb_line_mem_model;

  typedef struct {
    logic         rd_en;
    logic         wr_en;
    logic         byp;
    logic [31:0]  addr;
    logic [255:0] wd;
    logic [3:0]   be;
    logic         exp_valid;
    logic [255:0] exp_rd;
    logic         exp_err;
  } vec_t;

  localparam logic [255:0] L5   = {4{64'h0123456789ABCDEF}};
  localparam logic [255:0] L2   = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                                   32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [255:0] L2M  = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                                   32'h4444CCDD, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [255:0] WDB  = {{7{32'hFFFFFFFF}}, 32'hAABBCCDD};
  localparam logic [255:0] L0   = {8{32'h0BADF00D}};
  localparam logic [255:0] DEAD = {8{32'hDEADBEEF}};
  localparam int NV = 25;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         read = 1'b0, write = 1'b0, bypass = 1'b0;
  logic [31:0]  a = '0;
  logic [255:0] wd = '0;
  logic [3:0]   be = '0;

  logic         ready4, valid4, err4, ready6, valid6, err6;
  logic [255:0] rd4, rd6;
  logic [31:0]  rdc4, wrc4, rdc6, wrc6;

  int n_checks = 0;
  int n_fail = 0;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  line_mem_model u_dut4 (
    .master_clk (clk), .reset (reset), .a (a), .read (read), .write (write),
    .wd (wd), .be (be), .bypass (bypass), .ready (ready4), .rd (rd4),
    .valid (valid4), .err (err4), .rd_count (rdc4), .wr_count (wrc4)
  );

  line_mem_model #(.RD_LAT(6)) u_dut6 (
    .master_clk (clk), .reset (reset), .a (a), .read (read), .write (write),
    .wd (wd), .be (be), .bypass (bypass), .ready (ready6), .rd (rd6),
    .valid (valid6), .err (err6), .rd_count (rdc6), .wr_count (wrc6)
  );

  function automatic logic [31:0] la(input int line);
    return 32'(line) << 5;
  endfunction

  function automatic logic [255:0] ld(input int line);
    return {8{32'h10000000 + 32'(line)}};
  endfunction

  function automatic vec_t mkv(input logic r, input logic w, input logic b,
                               input logic [31:0] ad, input logic [255:0] d,
                               input logic [3:0] e, input logic ev,
                               input logic [255:0] er, input logic ee);
    vec_t v;
    v.rd_en = r; v.wr_en = w; v.byp = b; v.addr = ad; v.wd = d; v.be = e;
    v.exp_valid = ev; v.exp_rd = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    read = 1'b0; write = 1'b0; bypass = 1'b0; a = '0; wd = '0; be = '0;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(negedge clk);
      idle_inputs();
    end
  endtask

  // Six back-to-back reads of lines 10..15 against one instance; acceptance is taken
  // from that instance's ready, and each return is checked for order and latency.
  task automatic run_burst(input bit sel6);
    int exp_off [6];
    int acc_cyc [6];
    int lat, nacc, nret, s;
    logic r, v;
    logic [255:0] d;
    string tag;
    tag  = sel6 ? "b6" : "b4";
    lat  = sel6 ? 6 : 4;
    if (sel6) exp_off = '{0, 1, 2, 3, 6, 7};
    else      exp_off = '{0, 1, 2, 3, 4, 5};
    for (int k = 0; k < 6; k++) acc_cyc[k] = -100;
    nacc = 0; nret = 0; s = 0;
    for (int t = 0; t < 40 && nret < 6; t++) begin
      @(negedge clk);
      idle_inputs();
      read = (nacc < 6);
      a    = la(10 + nacc);
      #1;
      r = sel6 ? ready6 : ready4;
      v = sel6 ? valid6 : valid4;
      d = sel6 ? rd6 : rd4;
      if (v) begin
        if (nret < 6) begin
          chk($sformatf("%s_ret%0d_data", tag, nret), d, ld(10 + nret));
          chk($sformatf("%s_ret%0d_lat", tag, nret), 256'(t - acc_cyc[nret]), 256'(lat));
        end else begin
          chk($sformatf("%s_extra_valid", tag), 256'(1), 256'(0));
        end
        nret++;
      end
      if (read && r) begin
        if (nacc == 0) s = t;
        chk($sformatf("%s_acc%0d_cycle", tag, nacc), 256'(t - s), 256'(exp_off[nacc]));
        acc_cyc[nacc] = t;
        nacc++;
      end
    end
    chk($sformatf("%s_returns_within_budget", tag), 256'(nret), 256'(6));
  endtask

  initial begin
    tbl[0]  = mkv(0, 1, 0, la(5),    L5,   4'h0, 0, '0,   0);
    tbl[1]  = mkv(0, 1, 0, la(2),    L2,   4'h0, 0, '0,   0);
    tbl[2]  = mkv(1, 0, 0, la(5),    '0,   4'h0, 0, '0,   0);
    tbl[3]  = mkv(0, 1, 1, 32'h4C,   WDB,  4'h3, 0, '0,   0);
    tbl[4]  = mkv(1, 0, 0, la(2),    '0,   4'h0, 0, '0,   0);
    tbl[5]  = mkv(1, 0, 1, 32'h4C,   '0,   4'h0, 0, '0,   0);
    tbl[6]  = mkv(0, 0, 0, '0,       '0,   4'h0, 1, L5,   0);
    tbl[7]  = mkv(0, 0, 0, '0,       '0,   4'h0, 0, '0,   0);
    tbl[8]  = mkv(0, 0, 0, '0,       '0,   4'h0, 1, L2M,  0);
    tbl[9]  = mkv(0, 0, 0, '0,       '0,   4'h0, 1, 256'h4444CCDD, 0);
    tbl[10] = mkv(0, 1, 0, la(0),    L0,   4'h0, 0, '0,   0);
    tbl[11] = mkv(1, 1, 0, la(0),    '1,   4'h0, 0, '0,   0);
    tbl[12] = mkv(1, 0, 0, la(0),    '0,   4'h0, 0, '0,   1);
    tbl[13] = mkv(1, 0, 0, la(256),  '0,   4'h0, 0, '0,   1);
    tbl[14] = mkv(0, 1, 0, la(256),  '0,   4'h0, 0, '0,   1);
    tbl[15] = mkv(0, 0, 0, '0,       '0,   4'h0, 0, '0,   1);
    tbl[16] = mkv(0, 0, 0, '0,       '0,   4'h0, 1, L0,   1);
    tbl[17] = mkv(0, 0, 0, '0,       '0,   4'h0, 1, DEAD, 1);
    tbl[18] = mkv(0, 0, 0, '0,       '0,   4'h0, 0, '0,   1);
    for (int k = 0; k < 6; k++) tbl[19 + k] = mkv(0, 1, 0, la(10 + k), ld(10 + k), 4'h0, 0, '0, 1);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("por_ready", 256'(ready4), 256'(0));
    chk("por_valid", 256'(valid4), 256'(0));
    chk("por_rd", rd4, '0);
    chk("por_err", 256'(err4), 256'(0));
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      read = tbl[i].rd_en; write = tbl[i].wr_en; bypass = tbl[i].byp;
      a = tbl[i].addr; wd = tbl[i].wd; be = tbl[i].be;
      #1;
      chk($sformatf("row%0d_ready", i), 256'(ready4), 256'(1));
      chk($sformatf("row%0d_valid", i), 256'(valid4), 256'(tbl[i].exp_valid));
      chk($sformatf("row%0d_rd", i), rd4, tbl[i].exp_rd);
      chk($sformatf("row%0d_err", i), 256'(err4), 256'(tbl[i].exp_err));
    end

    // Reset clears the sticky error and the counters.
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_err_cleared", 256'(err4), 256'(0));
    chk("rst_ready_low", 256'(ready4), 256'(0));
    chk("rst_valid_low", 256'(valid4), 256'(0));
    chk("rst_rd_count", 256'(rdc4), 256'(0));
    chk("rst_wr_count", 256'(wrc4), 256'(0));
    reset = 1'b0;

    run_burst(1'b0);
    drain(15);
    run_burst(1'b1);
    drain(15);

    // Three reads in flight, then reset: nothing may come back.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_inputs();
      read = 1'b1;
      a = la(10 + k);
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("inflight_rst_ready", 256'(ready4), 256'(0));
    chk("inflight_rst_valid", 256'(valid4), 256'(0));
    chk("inflight_rst_rd", rd4, '0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d_valid4", k), 256'(valid4), 256'(0));
      chk($sformatf("post_rst%0d_valid6", k), 256'(valid6), 256'(0));
    end
    chk("post_rst_ready", 256'(ready4), 256'(1));
    chk("post_rst_rd_count", 256'(rdc4), 256'(0));

    // Array survives reset and the queue starts empty: one read returns at RD_LAT.
    begin
      int t;
      bit seen;
      @(negedge clk);
      read = 1'b1;
      a = la(10);
      t = 0;
      seen = 1'b0;
      while (t < 10 && !seen) begin
        @(negedge clk);
        idle_inputs();
        t++;
        #1;
        if (valid4) seen = 1'b1;
      end
      chk("after_rst_read_seen", 256'(seen), 256'(1));
      chk("after_rst_read_lat", 256'(t), 256'(4));
      chk("after_rst_read_data", rd4, ld(10));
    end

    drain(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
